// File: rtl/cmem_ctrl.sv
`timescale 1ns / 1ps
// Context-memory controller: arbitrates host bus accesses against kernel
// execution and sequences instruction-line fetches to all rows in parallel.
module cmem_ctrl #(
    parameter int unsigned N_ROW        = 4,
    parameter int unsigned IMEM_N_LINES = 128,
    parameter int unsigned DATA_WIDTH   = 32,
    localparam int unsigned ROW_W       = $clog2(N_ROW),
    localparam int unsigned LINE_W      = $clog2(IMEM_N_LINES)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    // host bus
    input  logic                                bus_req_i,
    output logic                                bus_gnt_o,
    input  logic                                bus_we_i,
    input  logic [ROW_W+LINE_W-1:0]             bus_addr_i,
    input  logic [DATA_WIDTH-1:0]               bus_wdata_i,
    output logic                                bus_rvalid_o,
    output logic [DATA_WIDTH-1:0]               bus_rdata_o,
    // kernel execution
    input  logic                                exec_start_i,
    input  logic [LINE_W-1:0]                   exec_pc_i,
    input  logic [LINE_W:0]                     exec_len_i,
    input  logic                                exec_stall_i,
    output logic                                exec_busy_o,
    output logic                                exec_done_o,
    output logic                                instr_valid_o,
    output logic [LINE_W-1:0]                   instr_pc_o,
    // context memories
    output logic [N_ROW-1:0]                    cm_row_req_o,
    output logic                                cm_we_o,
    output logic [LINE_W-1:0]                   cm_addr_o,
    output logic [DATA_WIDTH-1:0]               cm_wdata_o,
    input  logic [N_ROW-1:0][DATA_WIDTH-1:0]    cm_rdata_i
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   pc_q, pc_d;
    logic [LINE_W:0]     rem_q, rem_d;
    logic                fetch;

    logic                rvalid_q;
    logic                rd_we_q;
    logic [ROW_W-1:0]    rd_row_q;
    logic                instr_valid_q;
    logic [LINE_W-1:0]   instr_pc_q;

    logic [ROW_W-1:0]    bus_row;
    logic [LINE_W-1:0]   bus_line;

    assign bus_row  = bus_addr_i[ROW_W+LINE_W-1:LINE_W];
    assign bus_line = bus_addr_i[LINE_W-1:0];

    // Next-state and memory-side outputs; outputs are forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rem_d        = rem_q;
        fetch        = 1'b0;
        bus_gnt_o    = 1'b0;
        cm_row_req_o = '0;
        cm_we_o      = 1'b0;
        cm_addr_o    = '0;
        cm_wdata_o   = '0;
        if (rst_ni) begin
            unique case (state_q)
                StIdle: begin
                    // A start always beats a pending host access.
                    if (exec_start_i) begin
                        if (exec_len_i != '0) begin
                            pc_d    = exec_pc_i;
                            rem_d   = exec_len_i;
                            state_d = StRun;
                        end else begin
                            state_d = StFlush;
                        end
                    end else if (bus_req_i) begin
                        bus_gnt_o = 1'b1;
                        for (int r = 0; r < int'(N_ROW); r++) begin
                            cm_row_req_o[r] = (bus_row == ROW_W'(r));
                        end
                        cm_we_o    = bus_we_i;
                        cm_addr_o  = bus_line;
                        cm_wdata_o = bus_wdata_i;
                    end
                end
                StRun: begin
                    if (!exec_stall_i) begin
                        fetch        = 1'b1;
                        cm_row_req_o = '1;
                        cm_addr_o    = pc_q;
                        pc_d         = pc_q + 1'b1;  // wraps modulo IMEM_N_LINES
                        rem_d        = rem_q - 1'b1;
                        if (rem_q == (LINE_W + 1)'(1)) begin
                            state_d = StFlush;
                        end
                    end
                end
                StFlush: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM state, program counter and remaining-line counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
        end
    end

    // Bus response tracking: remember which row was granted and whether it was a read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rd_we_q  <= 1'b0;
            rd_row_q <= '0;
        end else begin
            rvalid_q <= bus_gnt_o;
            if (bus_gnt_o) begin
                rd_we_q  <= bus_we_i;
                rd_row_q <= bus_row;
            end
        end
    end

    // Fetch tag: memory data for the line fetched last cycle is on cm_rdata_i now.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
        end else begin
            instr_valid_q <= fetch;
            instr_pc_q    <= cm_addr_o;
        end
    end

    // Read data is muxed straight from the memories, which answer one cycle after grant.
    always_comb begin
        bus_rdata_o = '0;
        if (rvalid_q && !rd_we_q) begin
            bus_rdata_o = cm_rdata_i[rd_row_q];
        end
    end

    assign bus_rvalid_o  = rvalid_q;
    assign exec_busy_o   = (state_q != StIdle);
    assign exec_done_o   = (state_q == StFlush);
    assign instr_valid_o = instr_valid_q;
    assign instr_pc_o    = instr_pc_q;

endmodule

// File: doc/cmem_ctrl.md
# cmem_ctrl

Context-memory controller sitting directly upstream of the per-row CGRA context memories. It arbitrates between host bus accesses (kernel loading and read-back) and kernel execution. During execution it sequences a program counter that fetches one instruction line per cycle from all rows in parallel. It drives the shared row-request, write-enable, address and write-data lines of the context memories and reports fetch validity and kernel completion.

## Interface
- N_ROW, 4, number of CGRA rows / context memory banks; power of two
- IMEM_N_LINES, 128, lines per context memory; power of two
- DATA_WIDTH, 32, bus and instruction word width
- Derived: ROW_W = log2(N_ROW), LINE_W = log2(IMEM_N_LINES)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- bus_req_i  in  1  host access request
- bus_gnt_o  out  1  host access granted this cycle (combinational)
- bus_we_i  in  1  1 = write, 0 = read
- bus_addr_i  in  ROW_W+LINE_W  word address; {row, line}
- bus_wdata_i  in  DATA_WIDTH  write data
- bus_rvalid_o  out  1  response valid, one cycle after any grant
- bus_rdata_o  out  DATA_WIDTH  read data; 0 for writes
- exec_start_i  in  1  start kernel, single-cycle pulse
- exec_pc_i  in  LINE_W  first line of the kernel
- exec_len_i  in  LINE_W+1  number of lines to fetch (0..IMEM_N_LINES)
- exec_stall_i  in  1  hold fetch this cycle
- exec_busy_o  out  1  kernel in progress
- exec_done_o  out  1  single-cycle completion pulse
- instr_valid_o  out  1  cm rdata holds a freshly fetched line
- instr_pc_o  out  LINE_W  line address of the valid instruction
- cm_row_req_o  out  N_ROW  per-row memory request
- cm_we_o  out  1  memory write enable
- cm_addr_o  out  LINE_W  shared line address
- cm_wdata_o  out  DATA_WIDTH  shared write data
- cm_rdata_i  in  DATA_WIDTH x N_ROW  per-row read data, valid one cycle after request

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - If exec_start_i=1 and exec_len_i>0: load pc=exec_pc_i and remaining=exec_len_i, then go to RUN. exec_start_i wins over bus_req_i in the same cycle, so bus_gnt_o=0.
  - If exec_start_i=1 and exec_len_i=0: go to FLUSH with no fetch.
  - Otherwise, if bus_req_i=1: bus_gnt_o=1. Drive cm_row_req_o one-hot on the row field, with cm_we_o=bus_we_i, cm_addr_o=line field, cm_wdata_o=bus_wdata_i.
- RUN:
  - bus_gnt_o=0.
  - Each cycle with exec_stall_i=0: cm_row_req_o all ones, cm_we_o=0, cm_addr_o=pc; pc=pc+1 mod IMEM_N_LINES (wraps); remaining-1.
  - The fetch that brings remaining to 0 moves the FSM to FLUSH.
  - exec_stall_i=1: no request, pc and remaining hold.
- FLUSH: one cycle. exec_done_o=1, then back to IDLE. bus_gnt_o=0.
- exec_busy_o=1 in RUN and FLUSH.
- exec_start_i outside IDLE is ignored.
- Read response: the row index is registered at grant. Next cycle: bus_rvalid_o=1 and bus_rdata_o=cm_rdata_i[row] for reads, 0 for writes.
- Fetch output: instr_valid_o and instr_pc_o are registered copies of (fetch issued, cm_addr_o).
- Reset: all state cleared, FSM to IDLE. Reset mid-kernel aborts the kernel with no done pulse.

## Timing
- Reset values of registered outputs: exec_busy_o, exec_done_o, instr_valid_o, bus_rvalid_o = 0; instr_pc_o = 0; bus_rdata_o = 0.
- Combinational outputs under reset: bus_gnt_o, cm_row_req_o, cm_we_o = 0; cm_addr_o, cm_wdata_o = 0.
- Bus latency: grant in cycle T, response in T+1. Back-to-back grants allowed.
- Kernel of L lines with no stalls: start at T, fetches in T+1..T+L. instr_valid_o in T+2..T+L+1. exec_done_o in T+L+1, coincident with the last instr_valid_o. Back in IDLE at T+L+2.
- Each stall cycle shifts all later events by one.
- A bus request arriving during RUN/FLUSH waits (gnt=0). It is granted in the first IDLE cycle without a start.

## Test plan
- Load: write 0xA0000000+(row<<8)+line to all 4x128 lines, then read each back. Each rvalid arrives exactly 1 cycle after grant with matching data.
- Kernel pc=5, len=3, no stall: cm_addr_o=5,6,7 in consecutive cycles, row_req=4'b1111. instr_valid_o for 3 cycles with instr_pc_o 5,6,7. exec_done_o coincides with pc 7.
- Wrap: pc=126, len=4. Fetch order 126,127,0,1; done after 4 valid instructions.
- Stall plus contention: len=4 with exec_stall_i high for 2 cycles mid-run, and bus_req_i held throughout. Exactly 4 fetches, done delayed by 2 cycles. bus_gnt_o=0 until the cycle after FLUSH.
- Boundaries: len=0 gives exec_done_o 1 cycle after start with no cm_row_req_o. len=128 fetches all lines once. Simultaneous start and bus_req in IDLE gives gnt=0.
- Async reset asserted during RUN: all outputs 0 immediately, no done pulse. A new start after release runs normally.
